gcd_param: RTL and testbench

- Parametrised successor to the 16-bit GCD engine. Computes gcd(A,B) for WIDTH-bit unsigned operands using the subtract/swap algorithm, one step per clock.
- Adds a proper valid/ready handshake on both input and output, zero-operand handling, result hold under back-pressure, and a step counter for performance monitoring.
- Sits behind the custom-instruction decoder as a multi-cycle functional unit.

---
 rtl/gcd_param_if.sv | 25 ++
 rtl/gcd_param.sv | 89 ++++++++
 tb/tb_gcd_param.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/gcd_param_if.sv
// rtl/gcd_param_if.sv - operand/result handshake bundle for the gcd_param unit
interface gcd_param_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 17
);
  logic             iValid;
  logic [WIDTH-1:0] iA;
  logic [WIDTH-1:0] iB;
  logic             oReady;
  logic             oValid;
  logic             iReady;
  logic [WIDTH-1:0] oC;
  logic [CNT_W-1:0] oCycles;
  logic             oBusy;

  modport slave (
    input  iValid, iA, iB, iReady,
    output oReady, oValid, oC, oCycles, oBusy
  );

  modport master (
    output iValid, iA, iB, iReady,
    input  oReady, oValid, oC, oCycles, oBusy
  );
endinterface

// File: rtl/gcd_param.sv
// rtl/gcd_param.sv - subtract/swap GCD unit, one step per clock, with step counter
module gcd_param #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 17
) (
  input logic      iClk,
  input logic      iRst,
  gcd_param_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] c_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cyc_q;
  logic [CNT_W-1:0] cnt_inc;
  logic             load;
  logic             finish;

  // Count of BUSY cycles including the current one, pinned at the maximum.
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
  assign load    = bus.iValid && bus.oReady;
  assign finish  = (state == BUSY) && ((b_q == '0) || (a_q == '0));

  assign bus.oReady  = (state == IDLE) && !iRst;
  assign bus.oBusy   = (state == BUSY);
  assign bus.oValid  = (state == DONE);
  assign bus.oC      = c_q;
  assign bus.oCycles = cyc_q;

  // State register.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next state: accept in IDLE, iterate in BUSY, hold result in DONE until taken.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load) state_nxt = BUSY;
      BUSY:    if (finish) state_nxt = DONE;
      DONE:    if (bus.iReady) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand registers, step counter and result capture.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      a_q   <= '0;
      b_q   <= '0;
      c_q   <= '0;
      cnt_q <= '0;
      cyc_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            a_q   <= bus.iA;
            b_q   <= bus.iB;
            cnt_q <= '0;
          end
        end
        BUSY: begin
          cnt_q <= cnt_inc;
          if (b_q == '0) begin
            c_q   <= a_q;
            cyc_q <= cnt_inc;
          end else if (a_q == '0) begin
            c_q   <= b_q;
            cyc_q <= cnt_inc;
          end else if (a_q > b_q) begin
            a_q <= b_q;
            b_q <= a_q;
          end else begin
            b_q <= b_q - a_q;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_gcd_param.sv
// tb/tb_gcd_param.sv - directed and randomised checks of gcd_param
module tb_gcd_param;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   passed = 0;
  int   total = 0;

  always #5 clk = ~clk;

  gcd_param_if #(.WIDTH(16), .CNT_W(17)) bus16 ();
  gcd_param_if #(.WIDTH(16), .CNT_W(4))  bus4 ();
  gcd_param_if #(.WIDTH(8),  .CNT_W(17)) bus8 ();

  gcd_param #(.WIDTH(16), .CNT_W(17)) dut16 (.iClk(clk), .iRst(rst), .bus(bus16));
  gcd_param #(.WIDTH(16), .CNT_W(4))  dut4  (.iClk(clk), .iRst(rst), .bus(bus4));
  gcd_param #(.WIDTH(8),  .CNT_W(17)) dut8  (.iClk(clk), .iRst(rst), .bus(bus8));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int gcd_ref(input int a, input int b);
    int t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  function automatic int steps_ref(input int a, input int b);
    int n = 0;
    int t;
    forever begin
      n++;
      if (b == 0 || a == 0) return n;
      if (a > b) begin t = a; a = b; b = t; end
      else b = b - a;
    end
  endfunction

  task automatic op16(input int a, input int b, input int exp_c, input int exp_cyc,
                      input int stall, input bit pulse);
    int n;
    @(negedge clk);
    chk("ready16", bus16.oReady, 1);
    bus16.iA = a[15:0];
    bus16.iB = b[15:0];
    bus16.iValid = 1'b1;
    bus16.iReady = (stall == 0);
    @(negedge clk);
    bus16.iValid = 1'b0;
    chk("busy16", bus16.oBusy, 1);
    n = 0;
    while (!bus16.oValid && n < 70000) begin
      @(negedge clk);
      n++;
    end
    chk("valid16", bus16.oValid, 1);
    chk("c16", bus16.oC, exp_c);
    chk("cyc16", bus16.oCycles, exp_cyc);
    chk("lat16", n, exp_cyc);
    for (int i = 0; i < stall; i++) begin
      if (pulse) begin
        bus16.iValid = 1'b1;
        bus16.iA = 16'd100 + i[15:0];
        bus16.iB = 16'd3;
      end
      @(negedge clk);
      chk("hold_v16", bus16.oValid, 1);
      chk("hold_c16", bus16.oC, exp_c);
      chk("hold_cyc16", bus16.oCycles, exp_cyc);
      chk("hold_rdy16", bus16.oReady, 0);
    end
    bus16.iValid = 1'b0;
    bus16.iReady = 1'b1;
    @(negedge clk);
    chk("drop16", bus16.oValid, 0);
    chk("rdy_back16", bus16.oReady, 1);
    chk("idle_busy16", bus16.oBusy, 0);
    chk("keep_c16", bus16.oC, exp_c);
  endtask

  task automatic op8(input int a, input int b, input int stall);
    int n;
    int g;
    int s;
    g = gcd_ref(a, b);
    s = steps_ref(a, b);
    @(negedge clk);
    bus8.iA = a[7:0];
    bus8.iB = b[7:0];
    bus8.iValid = 1'b1;
    bus8.iReady = (stall == 0);
    @(negedge clk);
    bus8.iValid = 1'b0;
    n = 0;
    while (!bus8.oValid && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk("valid8", bus8.oValid, 1);
    chk("c8", bus8.oC, g);
    chk("cyc8", bus8.oCycles, s);
    repeat (stall) @(negedge clk);
    if (stall != 0) chk("hold_c8", bus8.oC, g);
    bus8.iReady = 1'b1;
    @(negedge clk);
    chk("drop8", bus8.oValid, 0);
  endtask

  initial begin
    int n;
    bus16.iValid = 0; bus16.iA = 0; bus16.iB = 0; bus16.iReady = 1;
    bus4.iValid  = 0; bus4.iA  = 0; bus4.iB  = 0; bus4.iReady  = 1;
    bus8.iValid  = 0; bus8.iA  = 0; bus8.iB  = 0; bus8.iReady  = 1;
    repeat (2) @(negedge clk);
    chk("rst_valid", bus16.oValid, 0);
    chk("rst_busy", bus16.oBusy, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", bus16.oReady, 1);
    chk("rst_c", bus16.oC, 0);
    chk("rst_cyc", bus16.oCycles, 0);

    op16(12, 8, 4, 6, 0, 0);
    op16(0, 0, 0, 1, 0, 0);
    op16(7, 0, 7, 1, 0, 0);
    op16(0, 5, 5, 1, 0, 0);
    op16(5, 5, 5, 2, 0, 0);
    op16(21, 14, 7, 6, 10, 1);
    op16(1, 65535, 1, 65536, 0, 0);

    // Step counter saturation on the narrow-counter instance.
    @(negedge clk);
    bus4.iA = 16'd1; bus4.iB = 16'd20; bus4.iValid = 1'b1;
    @(negedge clk);
    bus4.iValid = 1'b0;
    n = 0;
    while (!bus4.oValid && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("valid4", bus4.oValid, 1);
    chk("c4", bus4.oC, 1);
    chk("cyc4_sat", bus4.oCycles, 15);
    @(negedge clk);
    chk("drop4", bus4.oValid, 0);

    // Asynchronous reset in the middle of a long computation.
    @(negedge clk);
    bus16.iA = 16'd1; bus16.iB = 16'd1000; bus16.iValid = 1'b1;
    @(negedge clk);
    bus16.iValid = 1'b0;
    repeat (20) @(negedge clk);
    chk("mid_busy", bus16.oBusy, 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", bus16.oBusy, 0);
    chk("arst_valid", bus16.oValid, 0);
    chk("arst_c", bus16.oC, 0);
    chk("arst_cyc", bus16.oCycles, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("arst_ready", bus16.oReady, 1);
    chk("arst_idle", bus16.oBusy, 0);
    op16(9, 6, 3, 6, 0, 0);

    // Randomised pairs with random result stalls on the 8-bit instance.
    op8(0, 0, 0);
    op8(255, 1, 2);
    for (int i = 0; i < 100; i++)
      op8($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 3));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
